// File: rtl/instr_mem_loader.sv
// instr_mem_loader: receives a byte stream, packs each group of four bytes
// into a big-endian 32-bit word, and writes the words to instruction memory
// at addresses 0..memSize-1. busy stalls fetch; done marks the end of the load.
`timescale 1ns/1ps
module instr_mem_loader #(
    parameter int unsigned memSize   = 8,
    parameter int unsigned addrWidth = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    output logic                 write_enable,
    output logic [addrWidth-1:0] write_address,
    output logic [31:0]          write_data,
    output logic                 busy,
    output logic                 done
);

    localparam logic [addrWidth-1:0] LAST_WORD = addrWidth'(memSize - 1);
    localparam logic [addrWidth-1:0] WORD_ONE  = addrWidth'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q;
    logic [23:0]          shift_q;
    logic [1:0]           byte_cnt_q;
    logic [addrWidth-1:0] word_cnt_q;
    logic                 accept_c;

    // A byte is consumed only while the loader is offering ready.
    always_comb begin
        accept_c = byte_valid && byte_ready;
    end

    // Loader FSM; every output is registered and updated together with the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            shift_q       <= 24'd0;
            byte_cnt_q    <= 2'd0;
            word_cnt_q    <= '0;
            byte_ready    <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= 32'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    byte_cnt_q <= 2'd0;
                    word_cnt_q <= '0;
                    if (start) begin
                        state_q    <= LOAD;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                LOAD: begin
                    if (accept_c) begin
                        shift_q    <= {shift_q[15:0], byte_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        // Fourth byte completes the word: hand it to the memory next cycle.
                        if (byte_cnt_q == 2'd3) begin
                            write_data    <= {shift_q, byte_data};
                            write_address <= word_cnt_q;
                            write_enable  <= 1'b1;
                            byte_ready    <= 1'b0;
                            state_q       <= WRITE;
                        end
                    end
                end

                WRITE: begin
                    write_enable <= 1'b0;
                    if (word_cnt_q == LAST_WORD) begin
                        state_q <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        word_cnt_q <= word_cnt_q + WORD_ONE;
                        byte_ready <= 1'b1;
                        state_q    <= LOAD;
                    end
                end

                DONE: begin
                    // Address and data keep the last written word until a new load writes.
                    if (start) begin
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        byte_ready <= 1'b1;
                        byte_cnt_q <= 2'd0;
                        word_cnt_q <= '0;
                        state_q    <= LOAD;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: idle under reset, continuous and
// gapped loads, byte held across WRITE, reset mid-load, restart from DONE.
`timescale 1ns/1ps
module tb_instr_mem_loader;

    localparam int unsigned MEM_SIZE = 8;
    localparam int unsigned ADDR_W   = 5;
    localparam int          WAIT_MAX = 200;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              write_enable;
    logic [ADDR_W-1:0] write_address;
    logic [31:0]       write_data;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int overlap  = 0;
    int t0       = 0;

    logic [ADDR_W-1:0] wr_addr [$];
    logic [31:0]       wr_data [$];

    logic [7:0]  prog_bytes [32];
    logic [31:0] prog_words [8];

    always #5 clock = ~clock;

    instr_mem_loader #(
        .memSize   (MEM_SIZE),
        .addrWidth (ADDR_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_ready    (byte_ready),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .busy          (busy),
        .done          (done)
    );

    always @(posedge clock) cyc <= cyc + 1;

    // Capture each write strobe; ready must never overlap a write cycle.
    always @(negedge clock) begin
        if (write_enable === 1'b1) begin
            wr_addr.push_back(write_address);
            wr_data.push_back(write_data);
            if (byte_ready !== 1'b0) overlap++;
        end
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_byte_ready"},    32'(byte_ready),    32'd0);
        check32({tag, "_write_enable"},  32'(write_enable),  32'd0);
        check32({tag, "_write_address"}, 32'(write_address), 32'd0);
        check32({tag, "_write_data"},    write_data,         32'd0);
        check32({tag, "_busy"},          32'(busy),          32'd0);
        check32({tag, "_done"},          32'(done),          32'd0);
    endtask

    // Present one byte after a gap and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(negedge clock);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (byte_ready !== 1'b1 && n < WAIT_MAX) begin
            @(negedge clock);
            n++;
        end
        check32("ready_wait", 32'(n < WAIT_MAX), 32'd1);
        @(negedge clock);
    endtask

    // Pulse start for one cycle; the loader must be in LOAD afterwards.
    task automatic start_load(input string tag);
        byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        t0 = cyc;
        check32({tag, "_start_busy"},  32'(busy),       32'd1);
        check32({tag, "_start_done"},  32'(done),       32'd0);
        check32({tag, "_start_ready"}, 32'(byte_ready), 32'd1);
    endtask

    task automatic wait_done(input string tag, output int cycles);
        int n;
        n = 0;
        while (done !== 1'b1 && n < WAIT_MAX) begin
            @(negedge clock);
            n++;
        end
        check32({tag, "_done_wait"}, 32'(n < WAIT_MAX), 32'd1);
        cycles = cyc - t0;
    endtask

    task automatic check_words(input string tag, input int rot);
        logic [31:0] got_d;
        logic [31:0] got_a;
        check32({tag, "_write_count"}, 32'(wr_data.size()), 32'(MEM_SIZE));
        for (int i = 0; i < int'(MEM_SIZE); i++) begin
            got_d = (i < wr_data.size()) ? wr_data[i] : 32'hxxxx_xxxx;
            got_a = (i < wr_addr.size()) ? 32'(wr_addr[i]) : 32'hxxxx_xxxx;
            check32($sformatf("%s_addr%0d", tag, i), got_a, 32'(i));
            check32($sformatf("%s_data%0d", tag, i), got_d, prog_words[(i + rot) % 8]);
        end
    endtask

    // Hard stop if the sequence below ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        int gap;

        prog_bytes = '{8'h00, 8'h00, 8'h00, 8'h00,  8'h11, 8'h09, 8'h00, 8'h01,
                       8'h21, 8'h08, 8'h00, 8'h02,  8'hAD, 8'h88, 8'h00, 8'h00,
                       8'h8D, 8'h90, 8'h00, 8'h00,  8'h02, 8'h0A, 8'h40, 8'h22,
                       8'h08, 8'h00, 8'h00, 8'h00,  8'h00, 8'h00, 8'h00, 8'h00};
        prog_words = '{32'h0000_0000, 32'h1109_0001, 32'h2108_0002, 32'hAD88_0000,
                       32'h8D90_0000, 32'h020A_4022, 32'h0800_0000, 32'h0000_0000};

        // Reset held with noisy byte_valid: everything stays at zero.
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'hA5;
        #1;
        check_reset_outputs("reset_t0");
        repeat (4) begin
            @(negedge clock);
            byte_valid = ~byte_valid;
            #1;
        end
        check_reset_outputs("reset_hold");
        @(negedge clock);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clock);
            byte_valid = ~byte_valid;
        end
        #1;
        check_reset_outputs("idle_no_start");
        check32("idle_writes", 32'(wr_data.size()), 32'd0);
        @(negedge clock);

        // Continuous stream: 40 cycles from LOAD entry to DONE.
        start_load("cont");
        for (int i = 0; i < 32; i++) send_byte(prog_bytes[i], 0);
        byte_valid = 1'b0;
        wait_done("cont", cycles);
        check32("cont_cycles", 32'(cycles), 32'd40);
        check32("cont_busy_done", 32'(busy), 32'd0);
        check32("cont_ready_done", 32'(byte_ready), 32'd0);
        check32("cont_hold_addr", 32'(write_address), 32'd7);
        check_words("cont", 0);
        repeat (3) @(negedge clock);
        check32("done_stays", 32'(done), 32'd1);

        // Restart from DONE, gapped stream, stray start pulse mid-load.
        wr_addr.delete();
        wr_data.delete();
        start_load("gap");
        for (int i = 0; i < 32; i++) begin
            if (i == 9) begin
                byte_valid = 1'b0;
                start = 1'b1;
                @(negedge clock);
                start = 1'b0;
            end
            gap = int'($urandom_range(0, 5));
            send_byte(prog_bytes[i], gap);
        end
        byte_valid = 1'b0;
        wait_done("gap", cycles);
        check_words("gap", 0);

        // Reset after two words and two bytes of a third.
        wr_addr.delete();
        wr_data.delete();
        start_load("rst");
        for (int i = 0; i < 10; i++) send_byte(prog_bytes[(i + 4) % 32], 0);
        byte_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        check32("rst_write_count", 32'(wr_data.size()), 32'd2);
        check32("rst_w0", (wr_data.size() > 0) ? wr_data[0] : 32'hxxxx_xxxx, 32'h1109_0001);
        check32("rst_w1", (wr_data.size() > 1) ? wr_data[1] : 32'hxxxx_xxxx, 32'h2108_0002);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_outputs("rst_release");

        // Reload from address 0; byte 0x21 waits out the WRITE of word 0.
        wr_addr.delete();
        wr_data.delete();
        start_load("reload");
        for (int i = 0; i < 32; i++) send_byte(prog_bytes[(i + 4) % 32], 0);
        byte_valid = 1'b0;
        wait_done("reload", cycles);
        check32("reload_cycles", 32'(cycles), 32'd40);
        check_words("reload", 1);

        check32("ready_during_write", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Loads a program into the writable instruction memory before the processor runs. It accepts a byte stream over a valid/ready handshake and assembles each group of four bytes into one 32-bit big-endian instruction word. It writes the words to consecutive addresses starting at 0 and signals completion. It sits between the host/serial front end and the write port of the instruction memory. While busy is high, the processor's fetch stage is held in stall.

## Interface
- memSize, 8, number of 32-bit words to load (1..32)
- addrWidth, 5, width of write_address; 2^addrWidth >= memSize

- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  level, sampled each cycle; begins a load from IDLE or DONE
- byte_valid  input  1  byte_data holds a valid byte
- byte_data  input  8  program byte, most-significant byte of each word first
- byte_ready  output  1  loader accepts a byte this cycle
- write_enable  output  1  one-cycle write strobe to the instruction memory
- write_address  output  addrWidth  word address for the write
- write_data  output  32  assembled instruction word
- busy  output  1  high in LOAD and WRITE; drives the fetch stall
- done  output  1  high in DONE; all memSize words written

## Operation
- Reset values: state=IDLE, byte_ready=0, write_enable=0, write_address=0, write_data=0, busy=0, done=0. The internal byte counter and word counter are both 0.
- States: IDLE, LOAD, WRITE, DONE. All outputs are registered or decoded from state only; no input reaches an output combinationally.
- IDLE: if start=1, go to LOAD. Word counter=0, byte counter=0.
- LOAD: byte_ready=1, busy=1.
  - A byte is accepted on an edge where byte_valid && byte_ready.
  - The shift register becomes {shift[23:0], byte_data}.
  - The byte counter increments modulo 4.
  - On the 4th accepted byte (byte counter=3): load write_data with the full word, write_address with the word counter, and go to WRITE.
- WRITE: write_enable=1 for exactly one cycle, byte_ready=0, busy=1.
  - Next state: if word counter == memSize-1, go to DONE; otherwise increment the word counter and go to LOAD.
- DONE: done=1, busy=0, byte_ready=0. write_address and write_data hold the last written values.
  - start=1 clears done, resets both counters, and goes to LOAD.
- start is ignored in LOAD and WRITE.
- byte_valid outside LOAD is ignored, and no byte is consumed.
- Words beyond memSize are never written. The write address wraps only by a new start, never by counter overflow.
- Reset mid-load: go to IDLE immediately. The partial word is discarded. Words already written remain in memory; this block does not clear them.

## Timing
- Byte acceptance: at most one byte per cycle in LOAD.
- Latency: the 4th byte of a word is accepted at edge N. write_enable is high from edge N until edge N+1, with address and data stable for that whole cycle. LOAD resumes after edge N+1.
- Minimum load time, with byte_valid held high: 5*memSize cycles from entry into LOAD to entry into DONE.
- done rises at the edge after the last WRITE cycle. busy falls at that same edge.
- byte_ready is low during every WRITE cycle. The source must hold a byte that is valid but not yet accepted.

## Test plan
- Reset then idle: assert reset with start=0 and byte_valid toggling. All outputs stay 0, write_enable never pulses, and state remains IDLE.
- Full load, memSize=8, continuous stream:
  - Stimulus: bytes 00 00 00 00, 11 09 00 01, 21 08 00 02, AD 88 00 00, 8D 90 00 00, 02 0A 40 22, 08 00 00 00, 00 00 00 00.
  - Expected: exactly 8 write_enable pulses, addresses 0..7 in order, data 0x00000000, 0x11090001, 0x21080002, 0xAD880000, 0x8D900000, 0x020A4022, 0x08000000, 0x00000000.
  - Expected: done=1 exactly 40 cycles after LOAD entry.
- Gapped stream: deassert byte_valid for random 0-5 cycle gaps between bytes. Written words and addresses are identical to the continuous case, and no byte is dropped or duplicated.
- Byte held during WRITE: keep byte_valid=1 with byte 0x21 presented during the WRITE cycle of word 0. Expected: 0x21 is not consumed until LOAD resumes, and word 1 is 0x21080002.
- Reset mid-load: assert reset after 2 words plus 2 bytes of a third.
  - Expected: exactly 2 writes occurred, done=0, all outputs return to reset values, and state is IDLE.
  - Expected: a following start reloads from address 0.
- Restart from DONE: after a complete load, assert start. Expected: done falls next cycle, busy rises, and the next write goes to address 0. A start pulse asserted mid-load has no effect.
